// File: rtl/bus_arbiter_4m.sv
// Four-master bus arbiter: registered one-hot grant, bounded bursts, dead handover cycle.
// Define BUS_ARB_RR_EN for round-robin selection; otherwise fixed priority (req[0] highest).
module bus_arbiter_4m #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  output logic [3:0]       grant,
  output logic             busy,
  output logic             forced,
  output logic [CNT_W-1:0] burst_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HANDOVER
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic             forced_q, forced_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;

`ifdef BUS_ARB_RR_EN
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] w;
    logic [1:0] idx;
    w = '0;
    // Scan downward so the nearest index after l is written last.
    for (int i = 4; i >= 1; i--) begin
      idx = l + 2'(i);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction
`else
  function automatic logic [1:0] pick(input logic [3:0] r);
    logic [1:0] w;
    w = '0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) w = 2'(i);
    end
    return w;
  endfunction
`endif

  logic [1:0] win;
  logic [3:0] own_oh;
  logic       others;

  always_comb begin
`ifdef BUS_ARB_RR_EN
    win = pick(req, last_q);
`else
    win = pick(req);
`endif
    own_oh = 4'b0001 << last_q;
    others = |(req & ~own_oh);
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    forced_d = 1'b0;
    cnt_d    = cnt_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE, HANDOVER: begin
        if (|req) begin
          state_d = GRANT;
          grant_d = 4'b0001 << win;
          cnt_d   = ONE_C;
          last_d  = win;
        end else begin
          state_d = IDLE;
          grant_d = 4'b0000;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[last_q]) begin
          state_d = HANDOVER;
          grant_d = 4'b0000;
          cnt_d   = '0;
        end else if (cnt_q == MAX_C) begin
          if (others) begin
            state_d  = HANDOVER;
            grant_d  = 4'b0000;
            forced_d = 1'b1;
            cnt_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 4'b0000;
      forced_q <= 1'b0;
      cnt_q    <= '0;
      last_q   <= 2'd3;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      forced_q <= forced_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = |grant_q;
  assign forced    = forced_q;
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_4m.sv
// Self-checking bench for bus_arbiter_4m: directed + random steps vs a behavioural model.
// Honours BUS_ARB_RR_EN the same way as the design.
module tb_bus_arbiter_4m;

  localparam int MAXB = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req = 4'b1111;
  logic [3:0]    grant;
  logic          busy;
  logic          forced;
  logic [CW-1:0] burst_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model: owner = -1 means bus not owned this cycle.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = 3;
  bit m_forced = 1'b0;

  bus_arbiter_4m #(.MAX_BURST(MAXB), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .grant(grant),
    .busy(busy),
    .forced(forced),
    .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int choose(input logic [3:0] r, input int last);
    int idx;
`ifdef BUS_ARB_RR_EN
    for (int i = 1; i <= 4; i++) begin
      idx = (last + i) % 4;
      if (r[idx]) return idx;
    end
`else
    for (int i = 0; i < 4; i++) begin
      idx = i;
      if (r[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_cnt    = 0;
    m_last   = 3;
    m_forced = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int others;
    m_forced = 1'b0;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = choose(r, m_last);
        m_last  = m_owner;
        m_cnt   = 1;
      end
    end else begin
      others = 0;
      for (int i = 0; i < 4; i++)
        if (i != m_owner && r[i]) others = 1;
      if (!r[m_owner]) begin
        m_owner = -1;
        m_cnt   = 0;
      end else if (m_cnt == MAXB && others != 0) begin
        m_owner  = -1;
        m_cnt    = 0;
        m_forced = 1'b1;
      end else if (m_cnt < MAXB) begin
        m_cnt++;
      end
    end
  endtask

  function automatic logic [3:0] m_grant();
    if (m_owner < 0) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'(m_grant()));
    chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, ".forced"}, 32'(forced), 32'(m_forced));
    chk({tag, ".cnt"}, 32'(burst_cnt), 32'(m_cnt));
    chk({tag, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic step(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check_all(tag);
  endtask

  int fcount;
  logic [3:0] rr;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.grant", 32'(grant), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.forced", 32'(forced), 32'h0);
    chk("rst.cnt", 32'(burst_cnt), 32'h0);
    reset = 1'b0;
    step(4'b1111, "first");
    chk("first_is_m0", 32'(grant), 32'h1);

    step(4'b0000, "drop");
    step(4'b0000, "idle");

    fcount = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0100, "single");
      if (forced) fcount++;
    end
    chk("single.sat_cnt", 32'(burst_cnt), 32'(MAXB));
    chk("single.no_forced", 32'(fcount), 32'd0);

    step(4'b0000, "gap");
    step(4'b0000, "gap2");
    for (int i = 0; i < 8; i++) step(4'b0011, "preempt_hold");
    chk("preempt.m0", 32'(grant), 32'h1);
    step(4'b0011, "preempt_ho");
    chk("preempt.forced", 32'(forced), 32'h1);
    chk("preempt.gap", 32'(grant), 32'h0);
    step(4'b0011, "preempt_next");
`ifdef BUS_ARB_RR_EN
    chk("preempt.next_rr", 32'(grant), 32'h2);
`else
    chk("preempt.next_fix", 32'(grant), 32'h1);
`endif

    step(4'b0000, "clr");
    step(4'b0000, "clr2");
    step(4'b0010, "vol_own");
    step(4'b1010, "vol_hold");
    step(4'b1010, "vol_hold2");
    step(4'b1000, "vol_rel");
    chk("vol.gap_forced", 32'(forced), 32'h0);
    step(4'b1000, "vol_next");
    chk("vol.next", 32'(grant), 32'h8);
    chk("vol.cnt", 32'(burst_cnt), 32'h1);

    for (int i = 0; i < 40; i++) step(4'b1111, "all");

    for (int i = 0; i < 400; i++) begin
      rr = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rr = 4'b0000;
      step(rr, "rand");
    end

    step(4'b0000, "pre_ar");
    step(4'b0000, "pre_ar2");
    step(4'b0100, "ar_own");
    step(4'b0100, "ar_own2");
    chk("ar.before", 32'(grant), 32'h4);
    @(posedge clk);
    model_edge(4'b0100);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("ar.grant_now", 32'(grant), 32'h0);
    chk("ar.busy_now", 32'(busy), 32'h0);
    chk("ar.cnt_now", 32'(burst_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(4'b1000, "ar_after");
    chk("ar.after", 32'(grant), 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_arbiter_4m.md
Name: bus_arbiter_4m

Overview:
- Arbitrates the shared 32-bit bus among four requesting masters.
- Produces a registered one-hot grant that drives the bus data mux select directly; grant 4'b0000 selects the default source.
- Enforces a bounded burst length per grant and inserts one dead handover cycle between owners.
- Fixed-priority or round-robin selection, chosen at compile time.

Parameters:
- MAX_BURST, 8, maximum consecutive grant cycles per owner when another master is waiting; legal range 1..(2^CNT_W)-1.
- CNT_W, 4, width of the burst counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request per master; bit i = master i, level-sensitive.
- grant  output  4  registered one-hot grant, or 4'b0000; wired to the bus mux select.
- busy  output  1  high whenever grant != 4'b0000.
- forced  output  1  one-cycle pulse in the first HANDOVER cycle after a burst-limit preemption.
- burst_cnt  output  CNT_W  cycles the current owner has held the grant.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Reset takes effect immediately, independent of clk.
- Reset values: state=IDLE, grant=4'b0000, busy=0, forced=0, burst_cnt=0, last owner pointer=3.
- States: IDLE, GRANT, HANDOVER.
- IDLE:
  - grant=0000.
  - If any req bit is sampled high at edge k, the selected winner w gets grant=onehot(w) after edge k, so latency is 1 cycle.
  - On that edge: state -> GRANT, burst_cnt=1, last=w.
  - If req=0000, stay in IDLE.
- GRANT, evaluated each edge:
  - req[w]=0 -> HANDOVER, grant=0000, burst_cnt=0.
  - req[w]=1, burst_cnt=MAX_BURST, another req bit high -> HANDOVER, grant=0000, forced=1 for that cycle, burst_cnt=0.
  - req[w]=1, burst_cnt=MAX_BURST, no other request -> hold grant; burst_cnt saturates at MAX_BURST and does not wrap.
  - Otherwise hold grant and increment burst_cnt.
- HANDOVER:
  - Exactly one cycle with grant=0000.
  - At the exiting edge, arbitrate as in IDLE: any req -> GRANT with the new winner, burst_cnt=1; none -> IDLE.
  - The previous owner may win again if it is the selected winner.
- Winner selection: see Optional Feature.
- Grant is one-hot or zero at all times; two bits are never high in the same cycle.
- Requests raised or dropped in the same cycle as a release are handled by the rules above. Only the sampled req at the edge matters.
- Reset mid-burst: grant drops to 0000 immediately, without waiting for clk. Arbitration restarts from IDLE with last=3.
- busy is combinational from the grant register (|grant).
- forced is registered.

Optional Feature:
- Macro: BUS_ARB_RR_EN.
- Defined: round-robin. The search starts at index (last+1) mod 4 and wraps upward; the first asserted req wins.
- Undefined: fixed priority, req[0] highest and req[3] lowest. The last pointer is still maintained but does not affect selection.

Test Plan:
- Reset with req=4'b1111 held -> grant=0000 and busy=0 during reset. First edge after release gives grant=0001 in both builds.
- Single master: req=0100 held for 20 cycles -> grant=0100 one cycle after req; burst_cnt counts 1..8 then stays at 8; forced never pulses.
- Preemption: req=0011, MAX_BURST=8 -> master 0 holds for 8 cycles, then one HANDOVER cycle with grant=0000 and forced=1.
  - RR build: next grant=0010.
  - Fixed build: next grant=0001 again.
- Voluntary release: owner 0010 drops req after 3 cycles while req[3]=1 -> one cycle with grant=0000 and forced=0, then grant=1000 with burst_cnt=1.
- RR fairness (BUS_ARB_RR_EN): all four req held high -> grant sequence 0001, 1000... corrected: 0001, 0010, 0100, 1000, 0001. Each owner holds 8 cycles, separated by one zero cycle.
- Async reset mid-burst: assert reset between clk edges while grant=0100 -> grant=0000 immediately, before the next edge. After release with req=1000, grant=1000 one cycle later.
